ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs) followed by an LED mask, or 0xFF (reset).
- Produces the request-to-send sequence (inhibit, then start), shifts the frame on edges of the device clock, and checks the device ACK.
- Drives the open-drain PS/2 lines through drive-low enables. It shares ps2_clk and ps2_data with the keyboard receiver.
- busy is used at top level to hold the receiver off while a frame is in flight.

---
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift on device clock falls,
// ACK check and timeout. Drives the open-drain lines through drive-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int PMAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] SET_LAST = PW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_LIM    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [9:0]    frame, frame_nxt;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s, data_s, fall_ok;
    logic          ready_nxt, busy_nxt, done_nxt, clk_dl_nxt, data_dl_nxt, ack_nxt, to_nxt;

    function automatic logic [PW-1:0] sat_inc_p(input logic [PW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    // Falls caused by our own clock pull are not device clocks.
    assign fall_ok = clk_sync[2] & ~clk_sync[1] & ~ps2_clk_drive_low;

    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        tcnt_nxt    = tcnt;
        idx_nxt     = idx;
        frame_nxt   = frame;
        clk_dl_nxt  = ps2_clk_drive_low;
        data_dl_nxt = ps2_data_drive_low;
        ack_nxt     = ack_err;
        to_nxt      = timeout_err;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                clk_dl_nxt  = 1'b0;
                data_dl_nxt = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_nxt  = {1'b1, ~^tx_data, tx_data};
                    ack_nxt    = 1'b0;
                    to_nxt     = 1'b0;
                    pcnt_nxt   = '0;
                    clk_dl_nxt = 1'b1;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (pcnt == INH_LAST) begin
                    pcnt_nxt    = '0;
                    data_dl_nxt = 1'b1;
                    state_nxt   = REQ;
                end else begin
                    pcnt_nxt = sat_inc_p(pcnt);
                end
            end
            REQ: begin
                if (pcnt == SET_LAST) begin
                    clk_dl_nxt = 1'b0;
                    tcnt_nxt   = '0;
                    idx_nxt    = '0;
                    state_nxt  = SEND;
                end else begin
                    pcnt_nxt = sat_inc_p(pcnt);
                end
            end
            SEND, WAIT_ACK: begin
                tcnt_nxt = sat_inc_t(tcnt);
                if (tcnt_nxt == T_LIM) begin
                    clk_dl_nxt  = 1'b0;
                    data_dl_nxt = 1'b0;
                    to_nxt      = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else if (state == SEND) begin
                    if (fall_ok) begin
                        data_dl_nxt = ~frame[idx];
                        idx_nxt     = idx + 4'd1;
                        if (idx == 4'd9) state_nxt = WAIT_ACK;
                    end
                end else begin
                    data_dl_nxt = 1'b0;
                    if (fall_ok) begin
                        ack_nxt   = data_s;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            pcnt               <= '0;
            tcnt               <= '0;
            idx                <= '0;
            clk_sync           <= '1;
            data_sync          <= '1;
            tx_ready           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            ack_err            <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state              <= state_nxt;
            pcnt               <= pcnt_nxt;
            tcnt               <= tcnt_nxt;
            idx                <= idx_nxt;
            clk_sync           <= {clk_sync[1:0], ps2_clk_in};
            data_sync          <= {data_sync[0], ps2_data_in};
            tx_ready           <= ready_nxt;
            busy               <= busy_nxt;
            done               <= done_nxt;
            ps2_clk_drive_low  <= clk_dl_nxt;
            ps2_data_drive_low <= data_dl_nxt;
            ack_err            <= ack_nxt;
            timeout_err        <= to_nxt;
        end
    end

    always_ff @(posedge clk) begin
        frame <= frame_nxt;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard clocking model.
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int SETC = 10;
    localparam int TO   = 1500;
    localparam int H    = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       busy, done, ack_err, timeout_err;
    logic       kb_clk_low, kb_data_low;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    assign ps2_clk_in  = ~(ps2_clk_drive_low | kb_clk_low);
    assign ps2_data_in = ~(ps2_data_drive_low | kb_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SETC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic accept(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("errs_cleared", 32'({ack_err, timeout_err}), 32'd0);
    endtask

    // Measures the inhibit and setup phases; returns in the first SEND cycle.
    task automatic rts();
        int n;
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_drive_low && ps2_data_drive_low && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check("setup_len", n, SETC);
        check("start_bit", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd1);
    endtask

    task automatic kb_clocks(input int n, input bit ack, input bit inject, output logic [9:0] bits);
        bits = '0;
        for (int k = 1; k <= n; k++) begin
            if (k == 11) kb_data_low = ack;
            if (inject && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            kb_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data_in;
            if (inject && k == 3) check("ready_while_busy", 32'(tx_ready), 32'd0);
            kb_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            if (inject && k == 5) tx_valid = 1'b0;
        end
        kb_data_low = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input logic [9:0] exp_frame, input bit nack, input bit inject);
        int d0;
        int n;
        logic [9:0] bits;
        d0 = done_cnt;
        accept(b);
        rts();
        repeat (5) @(negedge clk);
        kb_clocks(11, !nack, inject, bits);
        n = 0;
        while (!tx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("ready_after_xfer", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check("frame_bits", 32'(bits), 32'(exp_frame));
        check("done_once", done_cnt - d0, 1);
        check("ack_err", 32'(ack_err), 32'(nack));
        check("timeout_err", 32'(timeout_err), 32'd0);
        check("idle_outputs", 32'({busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        logic [9:0] bits;
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hAA;
        kb_clk_low = 1'b0;
        kb_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_outs", 32'({busy, done, ps2_clk_drive_low, ps2_data_drive_low, ack_err, timeout_err}), 32'd0);
        rst = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(tx_ready), 32'd1);
        check("busy_after_rst", 32'(busy), 32'd0);

        xfer(8'hED, 10'h3ED, 1'b0, 1'b0);
        xfer(8'h07, 10'h207, 1'b0, 1'b0);
        xfer(8'h00, 10'h300, 1'b0, 1'b0);
        xfer(8'h3C, 10'h33C, 1'b1, 1'b0);
        xfer(8'hFF, 10'h3FF, 1'b0, 1'b1);

        // Device never clocks: transfer must abort on timeout.
        d0 = done_cnt;
        accept(8'h12);
        rts();
        n = 0;
        while (!done && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("timeout_len", n, TO);
        check("timeout_drives", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        check("timeout_flag", 32'({timeout_err, ack_err}), 32'd2);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check("timeout_done_once", done_cnt - d0, 1);

        // Reset after the fourth device clock.
        d0 = done_cnt;
        accept(8'hA5);
        rts();
        repeat (5) @(negedge clk);
        kb_clocks(4, 1'b1, 1'b0, bits);
        check("partial_bits", 32'(bits[3:0]), 32'h5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", 32'({busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        xfer(8'hF4, 10'h2F4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
